output_deskew: RTL and testbench
================================

OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 Parameter ARRAY_SIZE, default 8, number of lanes (systolic array columns); SHALL be at least 2.
REQ-002 Parameter DATA_WIDTH, default 32, width of each accumulator result lane.
REQ-003 Parameter COUNT_WIDTH, default 16, width of the vector counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  advance strobe; when low, all state SHALL hold.
REQ-007 start  input  1  single-cycle pulse that arms a collection run.
REQ-008 vec_expected  input  COUNT_WIDTH  number of aligned vectors in the run, sampled on an accepted start.
REQ-009 data_in  input  signed DATA_WIDTH x ARRAY_SIZE  skewed results; lane k arrives k cycles after lane 0.
REQ-010 valid_in  input  1  qualifies lane 0 of data_in in the current cycle.
REQ-011 data_out  output  signed DATA_WIDTH x ARRAY_SIZE  time-aligned result vector.
REQ-012 valid_out  output  1  data_out holds an aligned vector belonging to the active run.
REQ-013 vec_count  output  COUNT_WIDTH  aligned vectors emitted in the current run.
REQ-014 busy  output  1  high in the ACTIVE state.
REQ-015 done  output  1  one-cycle pulse when a run completes.
REQ-016 error  output  1  sticky flag for an aligned vector that arrives outside a run.

Function
REQ-017 Lane k SHALL be delayed by ARRAY_SIZE-1-k enabled cycles through a shift chain that resets to zero; lane ARRAY_SIZE-1 SHALL pass through combinationally.
REQ-018 valid_in SHALL be delayed by ARRAY_SIZE-1 enabled cycles in a 1-bit shift chain; its output is internal signal aligned_valid.
REQ-019 The alignment latency from lane 0 to data_out SHALL be exactly ARRAY_SIZE-1 enabled cycles, and all lanes of one vector SHALL appear on the same cycle.
REQ-020 With enable low, the shift chains, state, counters and flags SHALL hold, and valid_out and done SHALL be 0.
REQ-021 The FSM SHALL have the states IDLE, ACTIVE and DONE.
REQ-022 IDLE -> ACTIVE on enable and start with vec_expected != 0; vec_count SHALL clear to 0 and vec_expected SHALL be latched.
REQ-023 IDLE -> DONE on enable and start with vec_expected == 0.
REQ-024 In ACTIVE, valid_out SHALL equal aligned_valid and enable, and vec_count SHALL increment on each valid_out.
REQ-025 ACTIVE -> DONE in the cycle after the valid_out that brings vec_count to the latched value.
REQ-026 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE, and vec_count SHALL hold until the next accepted start.
REQ-027 start in ACTIVE or DONE SHALL be ignored.
REQ-028 aligned_valid with enable in IDLE or DONE SHALL set error and SHALL NOT assert valid_out or change vec_count; error SHALL clear only on reset or an accepted start.
REQ-029 valid_in during a run beyond vec_expected SHALL set error when it aligns after the run ends.
REQ-030 vec_count SHALL saturate at its maximum value and SHALL NOT wrap.

Reset
REQ-031 On rst, all shift chains SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-032 On rst, data_out lanes 0..ARRAY_SIZE-2, valid_out, vec_count, busy, done and error SHALL be 0 (lane ARRAY_SIZE-1 follows data_in).
REQ-033 A reset mid-run SHALL discard all in-flight data without asserting done.

Structure
REQ-034 The FSM state enum SHALL be defined in the shared package systolic_pkg, alongside the existing array-wide constants.
REQ-035 A sub-module delay_line (parameters DEPTH and WIDTH, enable, zero reset) SHALL be instantiated once per lane and once for valid; DEPTH=0 SHALL be a wire.

Verification
REQ-036 ARRAY_SIZE=4, start with vec_expected=3, three skewed vectors {1,2,3,4},{5,6,7,8},{9,10,11,12} -> valid_out 3 consecutive cycles with those vectors, starting 3 cycles after the first lane-0 input; done on the next cycle; vec_count=3.
REQ-037 Same stimulus with enable low for 2 cycles mid-stream -> identical vectors out, delayed by 2 cycles, with no valid_out or done while enable is low.
REQ-038 start with vec_expected=0 -> done the next cycle, valid_out never asserted.
REQ-039 valid_in while IDLE -> error=1 three cycles later, valid_out=0; a subsequent start clears error.
REQ-040 rst asserted while ACTIVE with 2 vectors in flight -> all outputs 0, no done, FSM in IDLE.
REQ-041 start asserted again while ACTIVE with vec_expected=9 -> ignored; the run completes at the original count.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: array-wide constants and shared state types for the systolic datapath.
package systolic_pkg;
  localparam int ARRAY_SIZE_DEF = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int COUNT_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} deskew_state_e;
endpackage

// File: rtl/output_deskew_if.sv
// output_deskew_if: skewed-in / aligned-out result bus of the deskew stage.
interface output_deskew_if import systolic_pkg::*; #(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);
  logic enable, start, valid_in, valid_out, busy, done, error;
  logic [COUNT_WIDTH-1:0] vec_expected, vec_count;
  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_in, data_out;
  modport master (
    output enable, start, vec_expected, data_in, valid_in,
    input  data_out, valid_out, vec_count, busy, done, error
  );
  modport slave (
    input  enable, start, vec_expected, data_in, valid_in,
    output data_out, valid_out, vec_count, busy, done, error
  );
endinterface

// File: rtl/delay_line.sv
// delay_line: enable-gated shift chain of DEPTH stages, cleared by reset; DEPTH 0 is a wire.
module delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst ^ en_i;
    assign q_o = d_i;
  end else begin : g_chain
    logic [DEPTH-1:0][WIDTH-1:0] chain_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) chain_q <= '0;
      else if (en_i) begin
        chain_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
      end
    end
    assign q_o = chain_q[DEPTH-1];
  end
endmodule

// File: rtl/output_deskew.sv
// output_deskew: realigns skewed systolic column results and frames them into counted runs.
module output_deskew import systolic_pkg::*; #(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  output_deskew_if.slave bus
);
  deskew_state_e state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, exp_q, exp_d;
  logic err_q, err_d, aligned_valid, stray, valid_out, done;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] lane_out;
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    delay_line #(.DEPTH(ARRAY_SIZE-1-k), .WIDTH(DATA_WIDTH)) u_lane (
      .clk(clk), .rst(rst), .en_i(bus.enable), .d_i(bus.data_in[k]), .q_o(lane_out[k])
    );
  end
  delay_line #(.DEPTH(ARRAY_SIZE-1), .WIDTH(1)) u_valid (
    .clk(clk), .rst(rst), .en_i(bus.enable), .d_i(bus.valid_in), .q_o(aligned_valid)
  );
  // an aligned vector seen outside ACTIVE is flagged in the same cycle it appears
  assign stray = bus.enable & aligned_valid & (state_q != ACTIVE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    exp_d = exp_q;
    err_d = err_q;
    valid_out = 1'b0;
    done = 1'b0;
    if (bus.enable) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = bus.vec_expected != '0 ? ACTIVE : DONE;
            cnt_d = '0;
            exp_d = bus.vec_expected;
            err_d = 1'b0;
          end
          err_d = err_d | stray;
        end
        ACTIVE: begin
          valid_out = aligned_valid;
          if (aligned_valid) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            state_d = cnt_d == exp_q ? DONE : ACTIVE;
          end
        end
        default: begin
          done = 1'b1;
          state_d = IDLE;
          err_d = err_q | stray;
        end
      endcase
    end
  end
  assign bus.data_out = lane_out;
  assign bus.valid_out = valid_out;
  assign bus.vec_count = cnt_q;
  assign bus.busy = state_q == ACTIVE;
  assign bus.done = done;
  assign bus.error = err_q | stray;
endmodule

// File: tb/tb_output_deskew.sv
// tb_output_deskew: directed checks of alignment, run framing, stalls, errors and reset.
module tb_output_deskew;
  localparam int N = 4;
  localparam int W = 32;
  localparam int C = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  output_deskew_if #(.ARRAY_SIZE(N), .DATA_WIDTH(W), .COUNT_WIDTH(C)) b ();
  output_deskew #(.ARRAY_SIZE(N), .DATA_WIDTH(W), .COUNT_WIDTH(C)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // vector i carries lane values 4*i+1 .. 4*i+4, e.g. vector 0 = {1,2,3,4}
  function automatic logic [N*W-1:0] pack(input int i);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(4*i + k + 1);
    return r;
  endfunction
  // stream step s of n vectors: lane k carries vector s-k
  task automatic drive(input int s, input int n);
    for (int k = 0; k < N; k++) b.data_in[k] = (s - k >= 0 && s - k < n) ? W'(4*(s-k) + k + 1) : '0;
    b.valid_in = s >= 0 && s < n;
  endtask
  initial begin
    int s;
    logic en;
    b.enable = 1'b0;
    b.start = 1'b0;
    b.vec_expected = '0;
    b.data_in = '0;
    b.valid_in = 1'b0;
    @(negedge clk);
    chk("rst_data", b.data_out, '0);
    chk("rst_valid", b.valid_out, 1'b0);
    chk("rst_cnt", b.vec_count, '0);
    chk("rst_busy", b.busy, 1'b0);
    chk("rst_done", b.done, 1'b0);
    chk("rst_err", b.error, 1'b0);
    tick();
    rst = 1'b0;
    b.enable = 1'b1;
    // basic run of three vectors
    b.start = 1'b1;
    b.vec_expected = 16'd3;
    @(negedge clk);
    chk("t1_busy_pre", b.busy, 1'b0);
    tick();
    b.start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      drive(t, 3);
      @(negedge clk);
      chk("t1_valid", b.valid_out, t >= 3 && t <= 5);
      if (t >= 3 && t <= 5) chk("t1_data", b.data_out, pack(t - 3));
      chk("t1_done", b.done, t == 6);
      chk("t1_busy", b.busy, t <= 5);
      chk("t1_cnt", b.vec_count, t <= 3 ? 0 : (t >= 6 ? 3 : t - 3));
      tick();
    end
    chk("t1_cnt_end", b.vec_count, 16'd3);
    chk("t1_err", b.error, 1'b0);
    // same run with a two-cycle enable stall
    b.start = 1'b1;
    b.vec_expected = 16'd3;
    drive(-1, 0);
    tick();
    b.start = 1'b0;
    s = 0;
    for (int t = 0; t < 10; t++) begin
      en = !(t == 2 || t == 3);
      b.enable = en;
      drive(s, 3);
      @(negedge clk);
      chk("t2_valid", b.valid_out, en && s >= 3 && s <= 5);
      if (en && s >= 3 && s <= 5) chk("t2_data", b.data_out, pack(s - 3));
      chk("t2_done", b.done, en && s == 6);
      tick();
      if (en) s++;
    end
    b.enable = 1'b1;
    chk("t2_cnt", b.vec_count, 16'd3);
    // zero-length run
    b.start = 1'b1;
    b.vec_expected = '0;
    drive(-1, 0);
    @(negedge clk);
    chk("t3_done_pre", b.done, 1'b0);
    tick();
    b.start = 1'b0;
    @(negedge clk);
    chk("t3_done", b.done, 1'b1);
    chk("t3_valid", b.valid_out, 1'b0);
    chk("t3_busy", b.busy, 1'b0);
    tick();
    @(negedge clk);
    chk("t3_done_post", b.done, 1'b0);
    chk("t3_cnt", b.vec_count, '0);
    // stray valid while idle
    drive(0, 1);
    tick();
    for (int c = 1; c < 5; c++) begin
      drive(c, 1);
      @(negedge clk);
      chk("t4_valid", b.valid_out, 1'b0);
      chk("t4_err", b.error, c >= 3);
      chk("t4_cnt", b.vec_count, '0);
      tick();
    end
    b.start = 1'b1;
    b.vec_expected = 16'd3;
    drive(-1, 0);
    @(negedge clk);
    chk("t4_err_hold", b.error, 1'b1);
    tick();
    b.start = 1'b0;
    @(negedge clk);
    chk("t4_err_clr", b.error, 1'b0);
    chk("t4_busy", b.busy, 1'b1);
    // reset with two vectors in flight
    drive(0, 3);
    tick();
    drive(1, 3);
    tick();
    b.data_in = '0;
    b.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_data", b.data_out, '0);
    chk("t5_valid", b.valid_out, 1'b0);
    chk("t5_cnt", b.vec_count, '0);
    chk("t5_busy", b.busy, 1'b0);
    chk("t5_done", b.done, 1'b0);
    chk("t5_err", b.error, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_valid_post", b.valid_out, 1'b0);
      chk("t5_done_post", b.done, 1'b0);
      chk("t5_busy_post", b.busy, 1'b0);
      tick();
    end
    chk("t5_err_post", b.error, 1'b0);
    // restart ignored mid-run; one surplus vector aligns after the run
    b.start = 1'b1;
    b.vec_expected = 16'd2;
    drive(-1, 0);
    tick();
    for (int t = 0; t < 8; t++) begin
      b.start = t == 1;
      b.vec_expected = t == 1 ? 16'd9 : 16'd2;
      drive(t, 3);
      @(negedge clk);
      chk("t6_valid", b.valid_out, t >= 3 && t <= 4);
      if (t >= 3 && t <= 4) chk("t6_data", b.data_out, pack(t - 3));
      chk("t6_done", b.done, t == 5);
      chk("t6_busy", b.busy, t <= 4);
      chk("t6_err", b.error, t >= 5);
      tick();
    end
    b.start = 1'b0;
    chk("t6_cnt", b.vec_count, 16'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
